// File: rtl/sram_model_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_model_pkg : FSM encoding and saturating increment for sram_ws_model
// Rev 1.0
// ---------------------------------------------------------------------------
package sram_model_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_wait = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // Holds at all-ones of a width-bit counter; width is limited to 1..32.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] top;
        top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= top) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_array : word storage with power-up fill, synchronous write port and
//              registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_array #(
    parameter int unsigned         ADDR_W = 16,
    parameter int unsigned         DATA_W = 8,
    parameter logic [DATA_W-1:0]   FILL   = '0
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned c_depth = 1 << ADDR_W;

    // Contents are preset once at time 0 and survive reset.
    logic [DATA_W-1:0] r_mem [c_depth] = '{default: FILL};
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sram_ws_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_ws_model : clocked SRAM model with programmable wait states,
//                 write-protect window and saturating access counters
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_ws_model
    import sram_model_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         DATA_W      = 8,
    parameter int unsigned         WAIT_STATES = 2,
    parameter logic [31:0]         WP_BASE     = 32'hC000,
    parameter logic [DATA_W-1:0]   FILL        = '0,
    parameter int unsigned         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              ceb,
    input  logic              rnw,
    input  logic              oeb,
    input  logic              wp,
    output logic              rdy,
    output logic              wp_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [3:0]        c_ws_init = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [ADDR_W-1:0] c_wp_base = ADDR_W'(WP_BASE);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rnw;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wp_err;
    logic [CNT_W-1:0]    r_rd_count;
    logic [CNT_W-1:0]    r_wr_count;
    logic [DATA_W-1:0]   w_rdata;

    logic                w_req;
    logic                w_finish;
    logic                w_acc_rnw;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_prot;
    logic                w_rd_en;
    logic                w_wr_en;
    logic                w_drop;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (!ceb) w_next = (WAIT_STATES == 0) ? c_st_done : c_st_wait;
            c_st_wait: begin
                if (ceb)                w_next = c_st_idle;
                else if (r_cnt == 4'd0) w_next = c_st_done;
            end
            c_st_done: if (ceb) w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // With zero wait states the request edge is also the completion edge, so
    // the live bus is used while still in IDLE.
    always_comb begin
        w_req       = (r_state == c_st_idle) && !ceb;
        w_finish    = !ceb && (((r_state == c_st_idle) && (WAIT_STATES == 0)) ||
                               ((r_state == c_st_wait) && (r_cnt == 4'd0)));
        w_acc_rnw   = (r_state == c_st_idle) ? rnw  : r_rnw;
        w_acc_addr  = (r_state == c_st_idle) ? addr : r_addr;
        w_acc_wdata = (r_state == c_st_idle) ? data : r_wdata;
        w_prot      = wp && (w_acc_addr >= c_wp_base);
        w_rd_en     = w_finish && w_acc_rnw;
        w_wr_en     = w_finish && !w_acc_rnw && !w_prot;
        w_drop      = w_finish && !w_acc_rnw && w_prot;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_rnw      <= 1'b0;
            r_wdata    <= '0;
            r_wp_err   <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_wp_err <= w_drop;
            if (w_req) begin
                r_addr  <= addr;
                r_rnw   <= rnw;
                r_wdata <= data;
                r_cnt   <= c_ws_init;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd_en) r_rd_count <= CNT_W'(sat_inc(32'(r_rd_count), CNT_W));
            if (w_wr_en) r_wr_count <= CNT_W'(sat_inc(32'(r_wr_count), CNT_W));
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .FILL   (FILL)
    ) u_array (
        .clk     (clk),
        .resetb  (resetb),
        .wr_en   (w_wr_en),
        .rd_en   (w_rd_en),
        .addr    (w_acc_addr),
        .wr_data (w_acc_wdata),
        .rd_data (w_rdata)
    );

    assign rdy      = (r_state == c_st_done);
    assign wp_err   = r_wp_err;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
    assign data     = ((r_state == c_st_done) && r_rnw && !ceb && !oeb) ? w_rdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_ws_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_ws_model : directed bench for sram_ws_model (2, 0 wait states and
//                    2-bit counters); an undriven bus floats to 'hFF
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sram_ws_model;

    logic        clk    = 1'b0;
    logic        resetb = 1'b0;
    logic [15:0] addr   = '0;
    logic        rnw    = 1'b1;
    logic        oeb    = 1'b1;
    logic        wp     = 1'b0;
    logic        drv    = 1'b0;
    logic [7:0]  wd     = '0;
    logic        ceb_a  = 1'b1;
    logic        ceb_b  = 1'b1;
    logic        ceb_c  = 1'b1;

    tri1 [7:0] data_a;
    tri1 [7:0] data_b;
    tri1 [7:0] data_c;
    assign data_a = drv ? wd : 8'hzz;
    assign data_b = drv ? wd : 8'hzz;
    assign data_c = drv ? wd : 8'hzz;

    logic        rdy_a, err_a, rdy_b, err_b, rdy_c, err_c;
    logic [15:0] rd_a, wr_a, rd_b, wr_b;
    logic [1:0]  rd_c, wr_c;

    always #5 clk = ~clk;

    sram_ws_model #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .resetb(resetb), .addr(addr), .data(data_a), .ceb(ceb_a), .rnw(rnw),
        .oeb(oeb), .wp(wp), .rdy(rdy_a), .wp_err(err_a), .rd_count(rd_a), .wr_count(wr_a)
    );
    sram_ws_model #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .resetb(resetb), .addr(addr), .data(data_b), .ceb(ceb_b), .rnw(rnw),
        .oeb(oeb), .wp(wp), .rdy(rdy_b), .wp_err(err_b), .rd_count(rd_b), .wr_count(wr_b)
    );
    sram_ws_model #(.WAIT_STATES(2), .CNT_W(2)) u_cnt2 (
        .clk(clk), .resetb(resetb), .addr(addr), .data(data_c), .ceb(ceb_c), .rnw(rnw),
        .oeb(oeb), .wp(wp), .rdy(rdy_c), .wp_err(err_c), .rd_count(rd_c), .wr_count(wr_c)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ceb, rnw, oeb, wp, drv;
        logic [15:0] a;
        logic [7:0]  d;
        logic        e_rdy, e_err;
        logic [15:0] e_rd, e_wr;
        logic        cd;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic ceb, rnw, oeb, wp, drv, input logic [15:0] a,
                               input logic [7:0] d, input logic e_rdy, e_err,
                               input logic [15:0] e_rd, e_wr, input logic cd, input logic [7:0] e_dat);
        vec_t r;
        r.ceb = ceb; r.rnw = rnw; r.oeb = oeb; r.wp = wp; r.drv = drv; r.a = a; r.d = d;
        r.e_rdy = e_rdy; r.e_err = e_err; r.e_rd = e_rd; r.e_wr = e_wr; r.cd = cd; r.e_dat = e_dat;
        return r;
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Full read on the 2-wait-state instance: data and count checked in DONE.
    task automatic read_a(input logic [15:0] a, input logic [7:0] exp_d, input logic [15:0] exp_rd);
        @(negedge clk);
        ceb_a = 1'b0; rnw = 1'b1; oeb = 1'b0; drv = 1'b0; addr = a;
        edge1(); edge1(); edge1();
        chk("read_a rdy", 32'(rdy_a), 32'd1);
        chk("read_a data", 32'(data_a), 32'(exp_d));
        chk("read_a rd_count", 32'(rd_a), 32'(exp_rd));
        @(negedge clk);
        ceb_a = 1'b1;
        edge1();
    endtask

    initial begin
        // ceb, rnw, oeb, wp, drv, addr, wdata | rdy, wp_err, rd_count, wr_count, check data, data
        vt.push_back(v(0,0,1,0,1,16'h1234,8'h5A, 0,0,0,0, 0,8'h00));
        vt.push_back(v(0,1,1,0,1,16'h0000,8'h00, 0,0,0,0, 0,8'h00));
        vt.push_back(v(0,1,1,0,1,16'h0000,8'h00, 1,0,0,1, 0,8'h00));
        vt.push_back(v(0,1,1,0,1,16'h0000,8'h00, 1,0,0,1, 0,8'h00));
        vt.push_back(v(1,1,1,0,0,16'h0000,8'h00, 0,0,0,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h1234,8'h00, 0,0,0,1, 1,8'hFF));
        vt.push_back(v(0,1,0,0,0,16'h1234,8'h00, 0,0,0,1, 1,8'hFF));
        vt.push_back(v(0,1,0,0,0,16'h1234,8'h00, 1,0,1,1, 1,8'h5A));
        vt.push_back(v(0,1,1,0,0,16'h1234,8'h00, 1,0,1,1, 1,8'hFF));
        vt.push_back(v(1,1,0,0,0,16'h1234,8'h00, 0,0,1,1, 1,8'hFF));
        vt.push_back(v(0,1,0,0,0,16'h0000,8'h00, 0,0,1,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h0000,8'h00, 0,0,1,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h0000,8'h00, 1,0,2,1, 1,8'h00));
        vt.push_back(v(1,1,1,0,0,16'h0000,8'h00, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,0,1,0,1,16'hC000,8'hFF, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,0,1,0,1,16'hC000,8'hFF, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hC000,8'hFF, 1,1,2,1, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hC000,8'hFF, 1,0,2,1, 0,8'h00));
        vt.push_back(v(1,1,1,0,0,16'hC000,8'h00, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 0,0,2,1, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 1,0,3,1, 1,8'h00));
        vt.push_back(v(1,1,0,0,0,16'hC000,8'h00, 0,0,3,1, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hC000,8'hFF, 0,0,3,1, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hC000,8'hFF, 0,0,3,1, 0,8'h00));
        vt.push_back(v(0,0,1,0,1,16'hC000,8'hFF, 1,0,3,2, 0,8'h00));
        vt.push_back(v(1,1,1,0,0,16'hC000,8'h00, 0,0,3,2, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 0,0,3,2, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 0,0,3,2, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hC000,8'h00, 1,0,4,2, 1,8'hFF));
        vt.push_back(v(1,1,1,0,0,16'hC000,8'h00, 0,0,4,2, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hBFFF,8'h3C, 0,0,4,2, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hBFFF,8'h3C, 0,0,4,2, 0,8'h00));
        vt.push_back(v(0,0,1,1,1,16'hBFFF,8'h3C, 1,0,4,3, 0,8'h00));
        vt.push_back(v(1,1,1,0,0,16'hBFFF,8'h00, 0,0,4,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hBFFF,8'h00, 0,0,4,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hBFFF,8'h00, 0,0,4,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'hBFFF,8'h00, 1,0,5,3, 1,8'h3C));
        vt.push_back(v(1,1,1,0,0,16'hBFFF,8'h00, 0,0,5,3, 0,8'h00));
        vt.push_back(v(0,0,1,0,1,16'h0010,8'h77, 0,0,5,3, 0,8'h00));
        vt.push_back(v(1,0,1,0,1,16'h0010,8'h77, 0,0,5,3, 0,8'h00));
        vt.push_back(v(1,1,1,0,0,16'h0010,8'h00, 0,0,5,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h0010,8'h00, 0,0,5,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h0010,8'h00, 0,0,5,3, 0,8'h00));
        vt.push_back(v(0,1,0,0,0,16'h0010,8'h00, 1,0,6,3, 1,8'h00));
        vt.push_back(v(1,1,1,0,0,16'h0010,8'h00, 0,0,6,3, 0,8'h00));

        // Power-up reset
        edge1(); edge1();
        chk("reset rdy_a", 32'(rdy_a), 32'd0);
        chk("reset wp_err_a", 32'(err_a), 32'd0);
        chk("reset rd_count_a", 32'(rd_a), 32'd0);
        chk("reset wr_count_a", 32'(wr_a), 32'd0);
        chk("reset rdy_b", 32'(rdy_b), 32'd0);
        chk("reset wp_err_b", 32'(err_b), 32'd0);
        chk("reset rdy_c", 32'(rdy_c), 32'd0);
        chk("reset wp_err_c", 32'(err_c), 32'd0);
        @(negedge clk);
        resetb = 1'b1;

        // Wait-state write/read, write protect, abort
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            ceb_a = vt[i].ceb; rnw = vt[i].rnw; oeb = vt[i].oeb; wp = vt[i].wp;
            drv = vt[i].drv; addr = vt[i].a; wd = vt[i].d;
            edge1();
            chk($sformatf("row%0d rdy", i), 32'(rdy_a), 32'(vt[i].e_rdy));
            chk($sformatf("row%0d wp_err", i), 32'(err_a), 32'(vt[i].e_err));
            chk($sformatf("row%0d rd_count", i), 32'(rd_a), 32'(vt[i].e_rd));
            chk($sformatf("row%0d wr_count", i), 32'(wr_a), 32'(vt[i].e_wr));
            if (vt[i].cd) chk($sformatf("row%0d data", i), 32'(data_a), 32'(vt[i].e_dat));
        end

        // Asynchronous reset in the middle of a write's wait states
        @(negedge clk);
        ceb_a = 1'b0; rnw = 1'b0; oeb = 1'b1; wp = 1'b0; drv = 1'b1; addr = 16'h0020; wd = 8'h99;
        edge1();
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        chk("midwait reset rdy", 32'(rdy_a), 32'd0);
        chk("midwait reset rd_count", 32'(rd_a), 32'd0);
        chk("midwait reset wr_count", 32'(wr_a), 32'd0);
        @(negedge clk);
        ceb_a = 1'b1; drv = 1'b0; resetb = 1'b1;
        edge1();
        read_a(16'h1234, 8'h5A, 16'd1);
        read_a(16'h0020, 8'h00, 16'd2);
        chk("after reset wr_count", 32'(wr_a), 32'd0);

        // Zero wait states: write, then reads split by a single ceb-high edge
        @(negedge clk);
        ceb_b = 1'b0; rnw = 1'b0; oeb = 1'b1; drv = 1'b1; addr = 16'h0040; wd = 8'h3C;
        edge1();
        chk("ws0 write rdy", 32'(rdy_b), 32'd1);
        chk("ws0 write wr_count", 32'(wr_b), 32'd1);
        @(negedge clk);
        ceb_b = 1'b1; drv = 1'b0; rnw = 1'b1;
        edge1();
        chk("ws0 idle rdy", 32'(rdy_b), 32'd0);
        @(negedge clk);
        ceb_b = 1'b0; oeb = 1'b0;
        edge1();
        chk("ws0 read1 rdy", 32'(rdy_b), 32'd1);
        chk("ws0 read1 data", 32'(data_b), 32'h3C);
        chk("ws0 read1 rd_count", 32'(rd_b), 32'd1);
        edge1();
        chk("ws0 held rdy", 32'(rdy_b), 32'd1);
        chk("ws0 held rd_count", 32'(rd_b), 32'd1);
        @(negedge clk);
        ceb_b = 1'b1;
        edge1();
        chk("ws0 gap rdy", 32'(rdy_b), 32'd0);
        @(negedge clk);
        ceb_b = 1'b0; oeb = 1'b1; addr = 16'h0041;
        edge1();
        chk("ws0 read2 rdy", 32'(rdy_b), 32'd1);
        chk("ws0 read2 oeb float", 32'(data_b), 32'hFF);
        chk("ws0 read2 rd_count", 32'(rd_b), 32'd2);
        @(negedge clk);
        oeb = 1'b0;
        #1;
        chk("ws0 read2 oeb drive", 32'(data_b), 32'h00);
        @(negedge clk);
        ceb_b = 1'b1;
        edge1();

        // 2-bit counters saturate at 3
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            ceb_c = 1'b0; rnw = 1'b1; oeb = 1'b0; drv = 1'b0; addr = 16'(n);
            edge1(); edge1(); edge1();
            chk($sformatf("cnt2 read%0d rdy", n), 32'(rdy_c), 32'd1);
            chk($sformatf("cnt2 read%0d rd_count", n), 32'(rd_c), (n > 3) ? 32'd3 : 32'(n));
            @(negedge clk);
            ceb_c = 1'b1;
            edge1();
        end
        chk("cnt2 wr_count", 32'(wr_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
